ins_sequencer: RTL and testbench

Instruction fetch/issue sequencer that feeds the master controller's `instruction` input from an on-chip program memory. It adds hardware loops through sequencer-only opcodes, so long convolution and pooling sweeps are encoded compactly. On a datapath stall it issues a harmless NOP word, so no controller counter ever double-steps.

---
 rtl/ins_sequencer_if.sv | 48 ++++
 rtl/ins_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ins_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_sequencer_if.sv
// ins_sequencer_if: signal bundle between the instruction sequencer, its
// program memory, the downstream master controller and the host that
// launches programs.
//
//   start, startAddr     host -> sequencer, launch request and entry address
//   stall                controller -> sequencer, back-pressure
//   progAddr, progRdEn   sequencer -> program memory read port
//   progData             program memory -> sequencer (1-cycle sync read)
//   instruction,insValid sequencer -> controller issue port
//   busy, done, error    status
//   loopLevel            hardware loop stack occupancy
//   seq_state            sequencer FSM state (debug visibility)
//
// Handshake: the issue port has no ready. A word is transferred on every
// rising edge where the sequencer is running and stall is low. While stall is
// high the sequencer holds its program counter and memory output and drives a
// NOP (insValid=0), so the controller never sees a word twice.
interface ins_sequencer_if #(
  parameter int PA       = 10,
  parameter int insWidth = 26,
  parameter int LD       = 4
);
  logic                  start;
  logic [PA-1:0]         startAddr;
  logic                  stall;
  logic [PA-1:0]         progAddr;
  logic                  progRdEn;
  logic [insWidth-1:0]   progData;
  logic [insWidth-1:0]   instruction;
  logic                  insValid;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [$clog2(LD):0]   loopLevel;
  logic [1:0]            seq_state;

  modport master (
    input  start, startAddr, stall, progData,
    output progAddr, progRdEn, instruction, insValid, busy, done, error,
           loopLevel, seq_state
  );

  modport slave (
    output start, startAddr, stall, progData,
    input  progAddr, progRdEn, instruction, insValid, busy, done, error,
           loopLevel, seq_state
  );
endinterface

// File: rtl/ins_sequencer.sv
// ins_sequencer: fetches words from an on-chip program memory and issues them
// to the master controller. LOOP_BEGIN / LOOP_END / HALT are consumed locally
// and implement counted hardware loops (nesting up to LD). A stalled or
// consumed slot is filled with a NOP word so controller counters never
// double-step.
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    ins_sequencer_if master modport (launch, memory port, issue port,
//          status, loop level, FSM state)
module ins_sequencer #(
  parameter int depth    = 2,
  parameter int W        = 16,
  parameter int insWidth = 4 + 2 + 2 * ((depth > 2) ? depth : 2)
                           + (((1 << depth) > W) ? (1 << depth) : W),
  parameter int PA       = 10,
  parameter int LD       = 4,
  parameter int CW       = 12
) (
  input  logic           CLK,
  input  logic           RST_N,
  ins_sequencer_if.master bus
);
  localparam int SW = $clog2(LD) + 1;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;

  localparam logic [3:0] OP_LOOP_BEGIN = 4'b0100;
  localparam logic [3:0] OP_LOOP_END   = 4'b0101;
  localparam logic [3:0] OP_HALT       = 4'b1111;
  localparam logic [3:0] OP_NOP        = 4'b1101;
  localparam logic [insWidth-1:0] NOP_WORD = {OP_NOP, {(insWidth-4){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [PA-1:0]         fetch_pc, pc_next, pc_plus1;
  logic [insWidth-1:0]   ins_q, ins_next;
  logic                  valid_q, valid_next;
  logic                  done_q, done_next;
  logic                  error_q, error_next;

  // Loop stack: return address (first body word) and remaining iterations.
  logic [SW-1:0]         sp;
  logic [PA-1:0]         stk_ret [LD];
  logic [CW-1:0]         stk_cnt [LD];
  logic [LW-1:0]         top_idx, push_idx;
  logic                  push, pop, dec, clear;

  logic [3:0]            opcode;
  logic [CW-1:0]         cnt_in;

  assign opcode   = bus.progData[insWidth-1 -: 4];
  // A zero count still runs the body once.
  assign cnt_in   = (bus.progData[CW-1:0] == '0) ? CW'(1) : bus.progData[CW-1:0];
  assign pc_plus1 = fetch_pc + PA'(1);
  assign top_idx  = LW'(sp - SW'(1));
  assign push_idx = LW'(sp);

  // Memory must not advance while the controller is stalled, otherwise the
  // word currently on progData would be lost.
  assign bus.progRdEn    = (state == S_FILL) || ((state == S_RUN) && !bus.stall);
  assign bus.progAddr    = fetch_pc;
  assign bus.instruction = ins_q;
  assign bus.insValid    = valid_q;
  assign bus.busy        = (state == S_FILL) || (state == S_RUN);
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.loopLevel   = sp;
  assign bus.seq_state   = state;

  always_comb begin
    state_next = state;
    pc_next    = fetch_pc;
    ins_next   = NOP_WORD;
    valid_next = 1'b0;
    done_next  = 1'b0;
    error_next = error_q;
    push       = 1'b0;
    pop        = 1'b0;
    dec        = 1'b0;
    clear      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          pc_next    = bus.startAddr;
          error_next = 1'b0;
          clear      = 1'b1;
          state_next = S_FILL;
        end
      end
      // One cycle for the synchronous memory to produce the word at fetch_pc.
      S_FILL: begin
        pc_next    = pc_plus1;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (!bus.stall) begin
          case (opcode)
            OP_LOOP_BEGIN: begin
              if (sp == SW'(LD)) begin
                error_next = 1'b1;
                clear      = 1'b1;
                state_next = S_IDLE;
              end else begin
                push    = 1'b1;
                pc_next = pc_plus1;
              end
            end
            OP_LOOP_END: begin
              if (sp == '0) begin
                error_next = 1'b1;
                clear      = 1'b1;
                state_next = S_IDLE;
              end else if (stk_cnt[top_idx] > CW'(1)) begin
                // Jump back: the refetch costs a FILL cycle.
                dec        = 1'b1;
                pc_next    = stk_ret[top_idx];
                state_next = S_FILL;
              end else begin
                pop     = 1'b1;
                pc_next = pc_plus1;
              end
            end
            OP_HALT: begin
              done_next  = 1'b1;
              state_next = S_IDLE;
            end
            default: begin
              ins_next   = bus.progData;
              valid_next = 1'b1;
              pc_next    = pc_plus1;
            end
          endcase
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
      ins_q    <= NOP_WORD;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
      ins_q    <= ins_next;
      valid_q  <= valid_next;
      done_q   <= done_next;
      error_q  <= error_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sp <= '0;
      for (int i = 0; i < LD; i++) begin
        stk_ret[i] <= '0;
        stk_cnt[i] <= '0;
      end
    end else if (clear) begin
      sp <= '0;
    end else if (push) begin
      // fetch_pc already points at the first body word.
      stk_ret[push_idx] <= fetch_pc;
      stk_cnt[push_idx] <= cnt_in;
      sp                <= sp + SW'(1);
    end else if (pop) begin
      sp <= sp - SW'(1);
    end else if (dec) begin
      stk_cnt[top_idx] <= stk_cnt[top_idx] - CW'(1);
    end
  end
endmodule

// File: tb/tb_ins_sequencer.sv
// tb_ins_sequencer: self-checking bench for ins_sequencer. A cycle trace
// table for a looped program with a stall burst, hand-written sequences for
// straight-line issue, nesting, faults and reset, and random nested-loop
// programs checked against an expansion model with random stalls.
module tb_ins_sequencer;
  localparam int PA = 10;
  localparam int IW = 26;
  localparam int LD = 4;
  localparam int CW = 12;
  localparam int PW = IW - 4;

  typedef logic [IW-1:0] word_t;
  typedef word_t wq_t[$];
  typedef struct {
    bit    stall;
    word_t ins;
    bit    valid;
    int    lvl;
    bit    busy;
    bit    done;
    bit    rden;
  } row_t;

  logic CLK;
  logic RST_N;

  ins_sequencer_if #(.PA(PA), .insWidth(IW), .LD(LD)) bus ();

  ins_sequencer #(
    .depth(2), .W(16), .insWidth(IW), .PA(PA), .LD(LD), .CW(CW)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  word_t mem [1024];
  word_t prog_q[$];
  word_t exp_q[$];
  row_t  tbl [19];
  int    n_checks = 0;
  int    n_pass   = 0;

  // ---------------- clock / memory model ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (bus.progRdEn) bus.progData <= mem[bus.progAddr];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- words ----------------
  function automatic word_t dp(input logic [3:0] op, input int payload);
    return {op, PW'(payload)};
  endfunction
  function automatic word_t lb(input int cnt);
    return {4'b0100, PW'(cnt)};
  endfunction

  localparam word_t NOP_W  = {4'b1101, 22'h0};
  localparam word_t LE_W   = {4'b0101, 22'h0};
  localparam word_t HALT_W = {4'b1111, 22'h0};

  word_t wa, wb, wc, wx, wy, wz, ww;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ins"},   64'(bus.instruction), 64'(NOP_W));
    check({tag, "_valid"}, 64'(bus.insValid), 64'(0));
    check({tag, "_addr"},  64'(bus.progAddr), 64'(0));
    check({tag, "_rden"},  64'(bus.progRdEn), 64'(0));
    check({tag, "_busy"},  64'(bus.busy), 64'(0));
    check({tag, "_done"},  64'(bus.done), 64'(0));
    check({tag, "_err"},   64'(bus.error), 64'(0));
    check({tag, "_lvl"},   64'(bus.loopLevel), 64'(0));
  endtask

  // ---------------- driver tasks ----------------
  function automatic void p(input word_t w);
    prog_q.push_back(w);
  endfunction

  task automatic load(input logic [PA-1:0] base);
    for (int i = 0; i < prog_q.size(); i++) mem[PA'(int'(base) + i)] = prog_q[i];
  endtask

  // Called #1 after an edge; returns #1 after the edge that sampled start.
  task automatic start_at(input logic [PA-1:0] a);
    bus.start     = 1'b1;
    bus.startAddr = a;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  // Runs a program until busy drops, scoreboarding every issued word.
  task automatic run_prog(input logic [PA-1:0] a, input int stall_pct,
                          output int max_lvl, output bit got_done, output bit got_err);
    bit prev_stall;
    int cyc;
    max_lvl = 0; got_done = 0; got_err = 0; prev_stall = 0;
    start_at(a);
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (prev_stall) check("stall_nop", 64'(bus.insValid), 64'(0));
      if (bus.insValid) begin
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("sb_issue", 64'(bus.instruction), 64'(exp_q.pop_front()));
      end
      if (int'(bus.loopLevel) > max_lvl) max_lvl = int'(bus.loopLevel);
      if (bus.error) got_err = 1;
      if (bus.done) got_done = 1;
      if (!bus.busy) break;
      prev_stall = ($urandom_range(0, 99) < stall_pct);
      bus.stall  = prev_stall;
      @(posedge CLK); #1;
    end
    bus.stall = 1'b0;
    check("run_timeout", 64'(cyc < 4000), 64'(1));
  endtask

  // ---------------- reference model ----------------
  function automatic word_t rand_dp();
    int op;
    op = $urandom_range(0, 15);
    while (op == 4 || op == 5 || op == 15) op = $urandom_range(0, 15);
    return dp(4'(op), int'($urandom));
  endfunction

  // Emits a random block into prog_q and returns the words it must issue:
  // a loop contributes its body's stream repeated max(cnt,1) times.
  function automatic wq_t gen_body(input int lvl);
    wq_t   out_q, inner;
    int    n, cnt, reps;
    word_t w;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      if (lvl < 2 && $urandom_range(0, 2) == 0) begin
        cnt = $urandom_range(0, 3);
        w = {4'b0100, PW'($urandom)};
        w[CW-1:0] = CW'(cnt);
        prog_q.push_back(w);
        inner = gen_body(lvl + 1);
        prog_q.push_back({4'b0101, PW'($urandom)});
        reps = (cnt == 0) ? 1 : cnt;
        for (int r = 0; r < reps; r++)
          for (int k = 0; k < inner.size(); k++) out_q.push_back(inner[k]);
      end else begin
        w = rand_dp();
        prog_q.push_back(w);
        out_q.push_back(w);
      end
    end
    return out_q;
  endfunction

  function automatic void set_row(input int i, input bit st, input word_t ins, input bit v,
                                  input int l, input bit b, input bit d, input bit r);
    tbl[i] = '{st, ins, v, l, b, d, r};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int          lvl;
    bit          gd, ge;
    wq_t         e;
    logic [PA-1:0] base;

    wa = dp(4'h1, 'h111); wb = dp(4'h2, 'h222); wc = dp(4'h3, 'h333);
    wx = dp(4'h6, 'hABC); wy = dp(4'h7, 'h1234); wz = dp(4'h0, 'h155555);
    ww = dp(4'hD, 'h77);

    RST_N = 1'b1; bus.start = 1'b0; bus.startAddr = '0; bus.stall = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = HALT_W;
    #2 RST_N = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Trace table: LOOP_BEGIN cnt=3 {X,Y} LOOP_END HALT, stall burst of 3,
    // plus stall during a FILL cycle which must be ignored.
    set_row(0,  0, NOP_W, 0, 0, 1, 0, 1);
    set_row(1,  0, NOP_W, 0, 0, 1, 0, 1);
    set_row(2,  0, NOP_W, 0, 1, 1, 0, 1);
    set_row(3,  1, wx,    1, 1, 1, 0, 0);
    set_row(4,  1, NOP_W, 0, 1, 1, 0, 0);
    set_row(5,  1, NOP_W, 0, 1, 1, 0, 0);
    set_row(6,  0, NOP_W, 0, 1, 1, 0, 1);
    set_row(7,  0, wy,    1, 1, 1, 0, 1);
    set_row(8,  1, NOP_W, 0, 1, 1, 0, 1);
    set_row(9,  0, NOP_W, 0, 1, 1, 0, 1);
    set_row(10, 0, wx,    1, 1, 1, 0, 1);
    set_row(11, 0, wy,    1, 1, 1, 0, 1);
    set_row(12, 0, NOP_W, 0, 1, 1, 0, 1);
    set_row(13, 0, NOP_W, 0, 1, 1, 0, 1);
    set_row(14, 0, wx,    1, 1, 1, 0, 1);
    set_row(15, 0, wy,    1, 1, 1, 0, 1);
    set_row(16, 0, NOP_W, 0, 0, 1, 0, 1);
    set_row(17, 0, NOP_W, 0, 0, 0, 1, 0);
    set_row(18, 0, NOP_W, 0, 0, 0, 0, 0);
    prog_q.delete(); p(lb(3)); p(wx); p(wy); p(LE_W); p(HALT_W); load(10'h000);
    start_at(10'h000);
    for (int i = 0; i < 19; i++) begin
      check($sformatf("tr%0d_ins", i),   64'(bus.instruction), 64'(tbl[i].ins));
      check($sformatf("tr%0d_valid", i), 64'(bus.insValid),    64'(tbl[i].valid));
      check($sformatf("tr%0d_lvl", i),   64'(bus.loopLevel),   64'(tbl[i].lvl));
      check($sformatf("tr%0d_busy", i),  64'(bus.busy),        64'(tbl[i].busy));
      check($sformatf("tr%0d_done", i),  64'(bus.done),        64'(tbl[i].done));
      bus.stall = tbl[i].stall;
      #1;
      check($sformatf("tr%0d_rden", i),  64'(bus.progRdEn),    64'(tbl[i].rden));
      @(posedge CLK); #1;
    end
    bus.stall = 1'b0;

    // Straight line with a start pulse during FILL that must be ignored.
    prog_q.delete(); p(wa); p(wb); p(wc); p(HALT_W); load(10'h010);
    start_at(10'h010);
    check("sl_addr", 64'(bus.progAddr), 64'(10'h010));
    bus.start = 1'b1; bus.startAddr = 10'h300;
    @(posedge CLK); #1; bus.start = 1'b0;
    check("sl_fill", 64'(bus.instruction), 64'(NOP_W));
    @(posedge CLK); #1; check("sl_a", 64'(bus.instruction), 64'(wa));
    check("sl_a_v", 64'(bus.insValid), 64'(1));
    @(posedge CLK); #1; check("sl_b", 64'(bus.instruction), 64'(wb));
    @(posedge CLK); #1; check("sl_c", 64'(bus.instruction), 64'(wc));
    check("sl_c_v", 64'(bus.insValid), 64'(1));
    @(posedge CLK); #1; check("sl_done", 64'(bus.done), 64'(1));
    check("sl_busy", 64'(bus.busy), 64'(0));
    check("sl_halt_v", 64'(bus.insValid), 64'(0));
    @(posedge CLK); #1; check("sl_done_pulse", 64'(bus.done), 64'(0));

    // Nested outer=2 inner=3 around Z, then cnt=0 loop around W.
    prog_q.delete();
    p(lb(2)); p(lb(3)); p(wz); p(LE_W); p(LE_W); p(lb(0)); p(ww); p(LE_W); p(HALT_W);
    load(10'h100);
    repeat (6) exp_q.push_back(wz);
    exp_q.push_back(ww);
    run_prog(10'h100, 0, lvl, gd, ge);
    check("nest_peak", 64'(lvl), 64'(2));
    check("nest_done", 64'(gd), 64'(1));
    check("nest_err", 64'(ge), 64'(0));
    check("nest_drain", 64'(exp_q.size()), 64'(0));
    check("nest_lvl_end", 64'(bus.loopLevel), 64'(0));

    // Stack overflow: LD+1 nested LOOP_BEGINs.
    prog_q.delete(); repeat (LD + 1) p(lb(1)); p(HALT_W); load(10'h080);
    run_prog(10'h080, 0, lvl, gd, ge);
    check("ovf_err", 64'(ge), 64'(1));
    check("ovf_done", 64'(gd), 64'(0));
    check("ovf_peak", 64'(lvl), 64'(LD));
    check("ovf_lvl", 64'(bus.loopLevel), 64'(0));
    check("ovf_ins", 64'(bus.instruction), 64'(NOP_W));

    // Bare LOOP_END, then recovery by a fresh start.
    prog_q.delete(); p(LE_W); p(HALT_W); load(10'h0A0);
    run_prog(10'h0A0, 0, lvl, gd, ge);
    check("bare_err", 64'(ge), 64'(1));
    @(posedge CLK); #1;
    check("err_sticky", 64'(bus.error), 64'(1));
    prog_q.delete(); p(wa); p(wb); p(HALT_W); load(10'h0C0);
    exp_q.push_back(wa); exp_q.push_back(wb);
    run_prog(10'h0C0, 0, lvl, gd, ge);
    check("rec_err", 64'(ge), 64'(0));
    check("rec_done", 64'(gd), 64'(1));
    check("rec_drain", 64'(exp_q.size()), 64'(0));

    // Random nested programs at random bases (covers address wrap) with stalls.
    for (int t = 0; t < 25; t++) begin
      prog_q.delete();
      e = gen_body(0);
      p(HALT_W);
      base = PA'($urandom);
      load(base);
      exp_q = e;
      run_prog(base, 25, lvl, gd, ge);
      check("rnd_done", 64'(gd), 64'(1));
      check("rnd_err", 64'(ge), 64'(0));
      check("rnd_drain", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end

    // Reset in the middle of a long loop, then a clean run.
    prog_q.delete(); p(lb(100)); p(wz); p(LE_W); p(HALT_W); load(10'h140);
    start_at(10'h140);
    repeat (12) @(posedge CLK);
    check("pre_rst_lvl", 64'(bus.loopLevel), 64'(1));
    #3 RST_N = 1'b0;
    #1 check_reset("rst_mid");
    @(posedge CLK); #1 RST_N = 1'b1;
    exp_q.push_back(wa); exp_q.push_back(wb); exp_q.push_back(wc);
    run_prog(10'h010, 0, lvl, gd, ge);
    check("post_rst_peak", 64'(lvl), 64'(0));
    check("post_rst_done", 64'(gd), 64'(1));
    check("post_rst_drain", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
